q8_8_addsub_arbiter: RTL and testbench

Shares one Q8.8 add/subtract datapath between NUM_REQ independent requesters. Each requester offers two 16-bit Q8.8 operands and an add/sub select over a valid/ready handshake. A round-robin arbiter grants one request at a time and latches its operands. The block returns a registered 17-bit result tagged with the requester index over a response valid/ready handshake. It sits between the sequencing clients of the fixed-point unit and the single combinational Q8_8_AddSub instance.

---
 rtl/q8_8_pkg.sv | 17 +
 rtl/Q8_8_AddSub.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/q8_8_addsub_arbiter.sv | 137 +++++++++++++
 tb/tb_q8_8_addsub_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/q8_8_pkg.sv
// Shared Q8.8 fixed-point definitions: datapath widths, op-select encodings
// and the sequencer FSM state type.
package q8_8_pkg;

  localparam int unsigned Q_W = 16;
  localparam int unsigned R_W = 17;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/Q8_8_AddSub.sv
// Combinational Q8.8 add/subtract; bit 16 of the result is carry (add) or
// borrow/wrap (sub), with no saturation.
module Q8_8_AddSub
  import q8_8_pkg::*;
(
  input  logic [Q_W-1:0] operand1,
  input  logic [Q_W-1:0] operand2,
  input  logic           add_sub,
  output logic [R_W-1:0] result
);

  logic [R_W-1:0] a_ext;
  logic [R_W-1:0] b_ext;

  assign a_ext  = {1'b0, operand1};
  assign b_ext  = {1'b0, operand2};
  assign result = (add_sub == OP_ADD) ? (a_ext + b_ext) : (a_ext - b_ext);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from ptr with wrap and returns the first
// requesting index as a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  logic             found;
  logic [IDX_W:0]   sum;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // candidate = (ptr + k) mod N, computed one bit wider to catch the wrap
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      if (!found && req[sum[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[sum[IDX_W-1:0]]   = 1'b1;
        index                   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/q8_8_addsub_arbiter.sv
// Shares one Q8.8 add/sub datapath among NUM_REQ requesters: round-robin
// grant in IDLE, compute in EXEC, hold a tagged registered result in RESP.
module q8_8_addsub_arbiter
  import q8_8_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_op1,
  input  logic [16*NUM_REQ-1:0]  req_op2,
  input  logic [NUM_REQ-1:0]     req_add_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [16:0]            rsp_result,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q;
  logic [Q_W-1:0]       op1_q, op2_q;
  logic                 add_sub_q;
  logic [R_W-1:0]       result_q;
  logic [15:0]          ops_done_q;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic [Q_W-1:0]       sel_op1, sel_op2;
  logic                 sel_add_sub;
  logic [R_W-1:0]       dp_result;
  logic                 accept;
  logic                 rsp_fire;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .index (grant_idx)
  );

  Q8_8_AddSub u_dp (
    .operand1 (op1_q),
    .operand2 (op2_q),
    .add_sub  (add_sub_q),
    .result   (dp_result)
  );

  assign accept   = (state_q == IDLE) && (|grant);
  assign rsp_fire = (state_q == RESP) && rsp_ready;

  always_comb begin
    sel_op1     = '0;
    sel_op2     = '0;
    sel_add_sub = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op1     = req_op1[i*Q_W +: Q_W];
        sel_op2     = req_op2[i*Q_W +: Q_W];
        sel_add_sub = req_add_sub[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs; req_ready is also gated by rst_n so it drops with the async reset
  always_comb begin
    req_ready = ((state_q == IDLE) && rst_n) ? grant : '0;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      id_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      add_sub_q  <= 1'b0;
      result_q   <= '0;
      ops_done_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        id_q      <= grant_idx;
        op1_q     <= sel_op1;
        op2_q     <= sel_op2;
        add_sub_q <= sel_add_sub;
      end
      if (state_q == EXEC) begin
        result_q <= dp_result;
      end
      if (rsp_fire) begin
        ops_done_q <= ops_done_q + 16'd1;
      end
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_q8_8_addsub_arbiter.sv
// Self-checking bench for q8_8_addsub_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_q8_8_addsub_arbiter;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_op1;
  logic [16*NREQ-1:0]  req_op2;
  logic [NREQ-1:0]     req_add_sub;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [16:0]         rsp_result;
  logic                busy;
  logic [15:0]         ops_done;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int exp_ops  = 0;

  q8_8_addsub_arbiter #(.NUM_REQ(NREQ), .ID_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_add_sub (req_add_sub),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub);
    logic [16:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return sub ? (ea - eb) : (ea + eb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic v);
    req_op1[i*16 +: 16] = a;
    req_op2[i*16 +: 16] = b;
    req_add_sub[i]      = s;
    req_valid[i]        = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_valid   = '1;
    req_op1     = '0;
    req_op2     = '0;
    req_add_sub = '0;
    rsp_ready   = 1'b1;
    #2;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (rsp_id !== 2'd0 || rsp_result !== 17'd0) begin fails++;
      $display("FAIL reset_rsp got id=%0d res=%h exp id=0 res=00000", rsp_id, rsp_result); end
    tests++; if (ops_done !== 16'd0) begin fails++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    tick();
  endtask

  // One isolated request from requester i; checks handshake timing and result.
  task automatic test_single_op(input string name, input int i, input logic [15:0] a,
                                input logic [15:0] b, input logic s, input logic [16:0] exp);
    logic [3:0] onehot;
    onehot = 4'b0001 << i;
    set_req(i, a, b, s, 1'b1);
    #1;
    tests++; if (req_ready !== onehot) begin fails++;
      $display("FAIL %s_grant got=%b exp=%b", name, req_ready, onehot); end
    tick();
    req_valid = '0;
    tests++; if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++;
      $display("FAIL %s_exec got rr=%b busy=%b rv=%b exp rr=0000 busy=1 rv=0", name, req_ready, busy, rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_result !== exp || rsp_id !== 2'(i)) begin fails++;
      $display("FAIL %s_rsp got v=%b res=%h id=%0d exp v=1 res=%h id=%0d", name, rsp_valid, rsp_result, rsp_id, exp, i); end
    rsp_ready = 1'b1;
    tick();
    exp_ops++;
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'(exp_ops)) begin fails++;
      $display("FAIL %s_done got v=%b busy=%b ops=%0d exp v=0 busy=0 ops=%0d", name, rsp_valid, busy, ops_done, exp_ops); end
  endtask

  task automatic test_fairness();
    logic [15:0] a [NREQ];
    logic [15:0] b [NREQ];
    logic        s [NREQ];
    int          prev_cyc;
    bit          seen;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 16'(16'h1000 * (i + 1) + i);
      b[i] = 16'($urandom);
      s[i] = 1'($urandom);
      set_req(i, a[i], b[i], s[i], 1'b1);
    end
    rsp_ready = 1'b1;
    prev_cyc  = 0;
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        tick();
        if (rsp_valid === 1'b1) seen = 1'b1;
      end
      tests++;
      if (!seen) begin
        fails++; $display("FAIL fair_timeout rsp %0d got=none exp=rsp_valid", k);
      end else begin
        if (rsp_id !== 2'(k % NREQ) || rsp_result !== ref_calc(a[k%NREQ], b[k%NREQ], s[k%NREQ])) begin
          fails++;
          $display("FAIL fair_rsp%0d got id=%0d res=%h exp id=%0d res=%h", k, rsp_id, rsp_result,
                   k % NREQ, ref_calc(a[k%NREQ], b[k%NREQ], s[k%NREQ]));
        end
        if (k > 0) begin
          tests++; if (cyc - prev_cyc != 3) begin fails++;
            $display("FAIL fair_spacing%0d got=%0d exp=3", k, cyc - prev_cyc); end
        end
        prev_cyc = cyc;
      end
    end
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    exp_ops   = 5;
    tests++; if (ops_done !== 16'd5) begin fails++; $display("FAIL fair_ops_done got=%0d exp=5", ops_done); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    // pointer is at 1 after the fairness run granted 0,1,2,3,0
    exp = ref_calc(16'h1234, 16'h0F0F, 1'b0);
    set_req(1, 16'h1234, 16'h0F0F, 1'b0, 1'b1);
    rsp_ready = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    set_req(2, 16'h0100, 16'h0200, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 10; c++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold%0d got v=%b res=%h id=%0d rr=%b exp v=1 res=%h id=1 rr=0000",
                 c, rsp_valid, rsp_result, rsp_id, req_ready, exp);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    exp_ops++;
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || ops_done !== 16'(exp_ops)) begin fails++;
      $display("FAIL bp_complete got v=%b ops=%0d exp v=0 ops=%0d", rsp_valid, ops_done, exp_ops); end
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_b2b_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== ref_calc(16'h0100, 16'h0200, 1'b1)) begin
      fails++; $display("FAIL bp_b2b_rsp got v=%b id=%0d res=%h exp v=1 id=2 res=%h", rsp_valid, rsp_id,
                        rsp_result, ref_calc(16'h0100, 16'h0200, 1'b1)); end
    rsp_ready = 1'b1;
    tick();
    exp_ops++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_req(3, 16'h2222, 16'h1111, 1'b0, 1'b1);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 17'd0 ||
        ops_done !== 16'd0 || req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_outputs got busy=%b v=%b id=%0d res=%h ops=%0d rr=%b exp all zero",
               busy, rsp_valid, rsp_id, rsp_result, ops_done, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0 || ops_done !== 16'd0) begin fails++;
        $display("FAIL midrst_quiet%0d got v=%b ops=%0d exp v=0 ops=0", c, rsp_valid, ops_done); end
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h0300 + i), 16'h0001, 1'b0, 1'b1);
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_first_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 17'h00301) begin fails++;
      $display("FAIL midrst_rsp got v=%b id=%0d res=%h exp v=1 id=0 res=00301", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Random valids/data/backpressure against a transaction-level model.
  task automatic test_random();
    logic        v [NREQ];
    logic [15:0] a [NREQ];
    logic [15:0] b [NREQ];
    logic        s [NREQ];
    int          phase;    // 0 waiting for grant, 1 computing, 2 holding response
    int          ptr;
    int          g;
    int          eid;
    logic [16:0] eres;
    logic [3:0]  exp_rr;
    do_reset();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    phase = 0; ptr = 0; eid = 0; eres = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i]) begin
          if ($urandom_range(2) == 0) begin
            v[i] = 1'b1; a[i] = 16'($urandom); b[i] = 16'($urandom); s[i] = 1'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          v[i] = 1'b0;
        end
        set_req(i, a[i], b[i], s[i], v[i]);
      end
      rsp_ready = ($urandom_range(2) != 0);
      #1;
      g = -1;
      if (phase == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        end
      end
      exp_rr = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      tests++;
      if (req_ready !== exp_rr || rsp_valid !== (phase == 2) || busy !== (phase != 0) ||
          ops_done !== 16'(exp_ops)) begin
        fails++;
        $display("FAIL rand_ctl c=%0d got rr=%b v=%b busy=%b ops=%0d exp rr=%b v=%b busy=%b ops=%0d",
                 c, req_ready, rsp_valid, busy, ops_done, exp_rr, phase == 2, phase != 0, exp_ops);
      end
      if (phase == 2) begin
        tests++;
        if (rsp_id !== 2'(eid) || rsp_result !== eres) begin
          fails++;
          $display("FAIL rand_rsp c=%0d got id=%0d res=%h exp id=%0d res=%h", c, rsp_id, rsp_result, eid, eres);
        end
      end
      case (phase)
        0: if (g >= 0) begin
             eid = g; eres = ref_calc(a[g], b[g], s[g]);
             ptr = (g + 1) % NREQ; v[g] = 1'b0; phase = 1;
           end
        1: phase = 2;
        default: if (rsp_ready) begin phase = 0; exp_ops = (exp_ops + 1) % 65536; end
      endcase
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op("add", 0, 16'h0108, 16'h0380, 1'b0, 17'h00488);
    test_single_op("sub", 2, 16'h0402, 16'h0008, 1'b1, 17'h003FA);
    test_single_op("wrap", 3, 16'h0008, 16'h0010, 1'b1, 17'h1FFF8);
    test_single_op("carry", 0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
